// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg: shared state encoding and image geometry for the fabric config loader
package fabric_cfg_pkg;
  localparam int DEF_NUM_LUT = 8;
  localparam int DEF_NUM_SB = 5;
  localparam int DEF_LUT_W = 32;
  localparam int DEF_SB_W = 16;
  localparam int CFG_WORDS = 1 + DEF_NUM_LUT + DEF_NUM_SB;
  localparam int IDX_W = $clog2(DEF_NUM_LUT > DEF_NUM_SB ? DEF_NUM_LUT : DEF_NUM_SB);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LUT, S_SB, S_DONE} state_t;
endpackage

// File: rtl/cfg_word_demux.sv
// cfg_word_demux: turns an accepted word into the one-hot write strobe of its target entry
module cfg_word_demux
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_LUT = DEF_NUM_LUT,
  parameter int NUM_SB = DEF_NUM_SB,
  parameter int IW = IDX_W
) (
  input  state_t             state,
  input  logic [IW-1:0]      idx,
  input  logic               hs,
  output logic [NUM_LUT-1:0] lut_we,
  output logic [NUM_SB-1:0]  sb_we
);
  always_comb begin
    lut_we = (hs && state == S_LUT) ? NUM_LUT'(1) << idx : '0;
    sb_we = (hs && state == S_SB) ? NUM_SB'(1) << idx : '0;
  end
endmodule

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams a header, LUT tables and switch-box words into fabric config storage
module fabric_config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_LUT = DEF_NUM_LUT,
  parameter int NUM_SB = DEF_NUM_SB,
  parameter int LUT_W = DEF_LUT_W,
  parameter int SB_W = DEF_SB_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [31:0]                    cfg_data,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  output logic [NUM_LUT*(LUT_W+1)-1:0]   lut_mem,
  output logic [NUM_SB*SB_W-1:0]         sb_cfg,
  output logic [NUM_LUT-1:0]             lut_we,
  output logic [NUM_SB-1:0]              sb_we,
  output logic                           busy,
  output logic                           done,
  output logic                           fabric_en
);
  localparam int IW = $clog2(NUM_LUT > NUM_SB ? NUM_LUT : NUM_SB);
  state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic mode, hs, seg_end, ready_d, busy_d, done_d;
  logic [NUM_LUT-1:0] lut_we_d;
  logic [NUM_SB-1:0] sb_we_d;
  logic [LUT_W-1:0] tbl [NUM_LUT];
  logic [SB_W-1:0] sb [NUM_SB];

  // a word offered in the same cycle as start is swallowed, never written
  assign hs = cfg_valid & cfg_ready & ~start;
  assign fabric_en = done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      cfg_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      cfg_ready <= ready_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

  always_comb begin
    seg_end = state == S_HDR || (state == S_LUT && idx == IW'(NUM_LUT - 1)) || (state == S_SB && idx == IW'(NUM_SB - 1));
    state_d = start ? S_HDR : !hs ? state : state == S_HDR ? S_LUT : state == S_LUT ? (seg_end ? S_SB : S_LUT) : (seg_end ? S_DONE : S_SB);
    idx_d = (start || (hs && seg_end)) ? '0 : hs ? idx + IW'(1) : idx;
  end

  // flags are decoded from the next state so they are registered alongside it
  always_comb begin
    busy_d = state_d == S_HDR || state_d == S_LUT || state_d == S_SB;
    ready_d = busy_d;
    done_d = state_d == S_DONE;
  end

  cfg_word_demux #(.NUM_LUT(NUM_LUT), .NUM_SB(NUM_SB), .IW(IW)) u_demux (
    .state(state), .idx(idx), .hs(hs), .lut_we(lut_we_d), .sb_we(sb_we_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mode <= 1'b0;
      lut_we <= '0;
      sb_we <= '0;
      for (int i = 0; i < NUM_LUT; i++) tbl[i] <= '0;
      for (int j = 0; j < NUM_SB; j++) sb[j] <= '0;
    end else begin
      lut_we <= lut_we_d;
      sb_we <= sb_we_d;
      if (hs && state == S_HDR) mode <= cfg_data[0];
      for (int i = 0; i < NUM_LUT; i++) if (lut_we_d[i]) tbl[i] <= cfg_data[LUT_W-1:0];
      for (int j = 0; j < NUM_SB; j++) if (sb_we_d[j]) sb[j] <= cfg_data[SB_W-1:0];
    end
  end

  for (genvar i = 0; i < NUM_LUT; i++) begin : g_lut
    assign lut_mem[i*(LUT_W+1) +: LUT_W+1] = {mode, tbl[i]};
  end
  for (genvar j = 0; j < NUM_SB; j++) begin : g_sb
    assign sb_cfg[j*SB_W +: SB_W] = sb[j];
  end
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: directed table-driven check of the fabric config loader
module tb_fabric_config_loader;
  logic clock = 1'b0;
  logic reset, start, cfg_valid, cfg_ready, busy, done, fabric_en;
  logic [31:0] cfg_data;
  logic [263:0] lut_mem;
  logic [79:0] sb_cfg;
  logic [7:0] lut_we;
  logic [4:0] sb_we;
  int total = 0;
  int bad = 0;
  int lut_cnt [8];
  int sb_cnt [5];
  int early;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  lut_we;
    logic [4:0]  sb_we;
    logic        done;
    logic        ready;
  } vec_t;
  vec_t vecs [17];

  always #5 clock = ~clock;

  fabric_config_loader dut (
    .clock(clock), .reset(reset), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .lut_mem(lut_mem), .sb_cfg(sb_cfg), .lut_we(lut_we), .sb_we(sb_we),
    .busy(busy), .done(done), .fabric_en(fabric_en)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lut_e(int i);
    return 64'(lut_mem[i*33 +: 33]);
  endfunction

  function automatic logic [63:0] sb_e(int j);
    return 64'(sb_cfg[j*16 +: 16]);
  endfunction

  function automatic logic [31:0] word(int k, logic [31:0] w0, logic [31:0] lb, logic [31:0] sbb);
    return k == 0 ? w0 : k <= 8 ? lb + 32'(k - 1) : sbb + 32'(k - 9);
  endfunction

  task automatic cyc(logic v, logic [31:0] d, logic s);
    cfg_valid = v;
    cfg_data = d;
    start = s;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) if (lut_we[i]) lut_cnt[i]++;
    for (int j = 0; j < 5; j++) if (sb_we[j]) sb_cnt[j]++;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 8; i++) lut_cnt[i] = 0;
    for (int j = 0; j < 5; j++) sb_cnt[j] = 0;
  endtask

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0001, 8'h00, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0000, 8'h01, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0001, 8'h02, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0002, 8'h04, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0003, 8'h08, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0004, 8'h10, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0005, 8'h20, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0006, 8'h40, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hA5A5_0007, 8'h80, 5'h00, 1'b0, 1'b1},
      '{1'b1, 32'hFFFF_1230, 8'h00, 5'h01, 1'b0, 1'b1},
      '{1'b1, 32'hFFFF_1231, 8'h00, 5'h02, 1'b0, 1'b1},
      '{1'b1, 32'hFFFF_1232, 8'h00, 5'h04, 1'b0, 1'b1},
      '{1'b1, 32'hFFFF_1233, 8'h00, 5'h08, 1'b0, 1'b1},
      '{1'b1, 32'hFFFF_1234, 8'h00, 5'h10, 1'b1, 1'b0},
      '{1'b1, 32'h0BAD_0000, 8'h00, 5'h00, 1'b1, 1'b0},
      '{1'b1, 32'h0BAD_0001, 8'h00, 5'h00, 1'b1, 1'b0},
      '{1'b1, 32'h0BAD_0002, 8'h00, 5'h00, 1'b1, 1'b0}
    };
    reset = 1'b1;
    start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    clr_cnt();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_ready", 64'(cfg_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_fen", 64'(fabric_en), 0);
    chk("rst_lut_mem", 64'(|lut_mem), 0);
    chk("rst_sb_cfg", 64'(|sb_cfg), 0);
    reset = 1'b0;
    cyc(1, 32'h1, 0);
    chk("idle_ready", 64'(cfg_ready), 0);
    chk("idle_we", 64'({lut_we, sb_we}), 0);

    // back-to-back full load, then valid held high after done
    cyc(0, 0, 1);
    chk("start_busy", 64'(busy), 1);
    chk("start_ready", 64'(cfg_ready), 1);
    chk("start_done", 64'(done), 0);
    clr_cnt();
    for (int k = 0; k < 17; k++) begin
      cyc(vecs[k].valid, vecs[k].data, 0);
      chk($sformatf("v%0d_lut_we", k), 64'(lut_we), 64'(vecs[k].lut_we));
      chk($sformatf("v%0d_sb_we", k), 64'(sb_we), 64'(vecs[k].sb_we));
      chk($sformatf("v%0d_done", k), 64'(done), 64'(vecs[k].done));
      chk($sformatf("v%0d_ready", k), 64'(cfg_ready), 64'(vecs[k].ready));
    end
    chk("b2b_lut3", lut_e(3), 64'h1_A5A5_0003);
    chk("b2b_sb4", sb_e(4), 64'h1234);
    chk("b2b_fen", 64'(fabric_en), 1);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_lut%0d_cnt", i), 64'(lut_cnt[i]), 1);
    for (int j = 0; j < 5; j++) chk($sformatf("b2b_sb%0d_cnt", j), 64'(sb_cnt[j]), 1);

    // half-rate stream: done 27 cycles after the first handshake
    cyc(0, 0, 1);
    chk("rs_done_clr", 64'(done), 0);
    chk("rs_fen_clr", 64'(fabric_en), 0);
    for (int c = 0; c < 27; c++) begin
      cyc(c % 2 == 0, word(c / 2, 32'h1, 32'hA5A5_0000, 32'hFFFF_1230), 0);
      if (c == 25) chk("slow_done_early", 64'(done), 0);
      if (c == 26) chk("slow_done", 64'(done), 1);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("slow_lut%0d", i), lut_e(i), 64'h1_A5A5_0000 + 64'(i));
    for (int j = 0; j < 5; j++) chk($sformatf("slow_sb%0d", j), sb_e(j), 64'h1230 + 64'(j));

    // restart coincident with a valid word mid-load
    cyc(0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, word(k, 32'h1, 32'h1111_0000, 32'h0), 0);
    chk("part_lut0", lut_e(0), 64'h1_1111_0000);
    chk("part_lut3", lut_e(3), 64'h1_1111_0003);
    cyc(1, 32'hDEAD_BEEF, 1);
    chk("rs_lut_we", 64'(lut_we), 0);
    chk("rs_lut4", lut_e(4), 64'h1_A5A5_0004);
    chk("rs_busy", 64'(busy), 1);
    chk("rs_ready", 64'(cfg_ready), 1);
    chk("rs_done", 64'(done), 0);
    early = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(1, word(k, 32'h0, 32'h5A5A_0000, 32'h0000_4440), 0);
      if (k < 13 && done) early++;
    end
    chk("rs_done_early", 64'(early), 0);
    chk("rs_done_end", 64'(done), 1);
    chk("rs_lut0", lut_e(0), 64'h0_5A5A_0000);
    chk("rs_lut4_new", lut_e(4), 64'h0_5A5A_0004);
    chk("rs_sb2", sb_e(2), 64'h4442);

    // holding valid after done changes nothing
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'hFFFF_FFFF, 0);
      chk($sformatf("hold%0d_we", k), 64'({lut_we, sb_we}), 0);
      chk($sformatf("hold%0d_ready", k), 64'(cfg_ready), 0);
    end
    chk("hold_lut7", lut_e(7), 64'h0_5A5A_0007);
    chk("hold_sb4", sb_e(4), 64'h4444);

    // reset on the 10th handshake beats a simultaneous start
    cyc(0, 0, 1);
    for (int k = 0; k < 9; k++) cyc(1, word(k, 32'h1, 32'h7777_0000, 32'h0), 0);
    reset = 1'b1;
    cyc(1, word(9, 32'h1, 32'h7777_0000, 32'h0), 1);
    reset = 1'b0;
    chk("mr_lut_mem", 64'(|lut_mem), 0);
    chk("mr_sb_cfg", 64'(|sb_cfg), 0);
    chk("mr_we", 64'({lut_we, sb_we}), 0);
    chk("mr_ready", 64'(cfg_ready), 0);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_done", 64'(done | fabric_en), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h1234_5678, 0);
      chk($sformatf("mr_idle%0d_ready", k), 64'(cfg_ready), 0);
      chk($sformatf("mr_idle%0d_we", k), 64'({lut_we, sb_we}), 0);
    end
    chk("mr_idle_mem", 64'(|lut_mem), 0);

    // only bit 0 of the header is the mode
    cyc(0, 0, 1);
    for (int k = 0; k < 14; k++) cyc(1, word(k, 32'hFFFF_FFFE, 32'h3333_0000, 32'h0000_9990), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("mode0_lut%0d", i), lut_e(i) >> 32, 0);
    chk("mode0_lut5", lut_e(5), 64'h0_3333_0005);
    chk("mode0_done", 64'(done), 1);
    chk("mode0_fen", 64'(fabric_en), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fabric_config_loader.md
# fabric_config_loader

Configuration sequencer for the LUT/switch-box fabric (`fpga` top). It accepts a 32-bit configuration word stream over a valid/ready handshake and distributes it:
- word 0 supplies the global LUT mode bit;
- words 1..8 are the LUT truth tables;
- words 9..13 are the switch-box routing words.

It asserts `done`/`fabric_en` once the full image is loaded. This replaces hierarchical pokes of `ltN.mem` and `sbN.configure` with a synthesizable load path.

## Interface
- `NUM_LUT`, 8, number of LUT targets
- `NUM_SB`, 5, number of switch-box targets
- `LUT_W`, 32, truth-table bits per LUT (entry stored as `LUT_W+1` with mode bit on top)
- `SB_W`, 16, switch-box configure width (low `SB_W` bits of word used)
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin (or restart) a load
- `cfg_data` in 32: configuration word
- `cfg_valid` in 1: `cfg_data` valid
- `cfg_ready` out 1: loader accepts a word this cycle
- `lut_mem` out `NUM_LUT*(LUT_W+1)`: entry i at `[(i+1)*(LUT_W+1)-1 : i*(LUT_W+1)]` = `{mode, table_i}`
- `sb_cfg` out `NUM_SB*SB_W`: entry j at `[(j+1)*SB_W-1 : j*SB_W]`
- `lut_we` out `NUM_LUT`: one-cycle one-hot pulse when entry i updates
- `sb_we` out `NUM_SB`: one-cycle one-hot pulse when entry j updates
- `busy` out 1: load in progress
- `done` out 1: full image loaded (level)
- `fabric_en` out 1: equals `done`; enables fabric evaluation

## Operation
- States:
  - IDLE: `cfg_ready=0`.
  - HDR: expects word 0, `cfg_ready=1`.
  - LUT: `cfg_ready=1`, idx 0..`NUM_LUT-1`.
  - SB: `cfg_ready=1`, idx 0..`NUM_SB-1`.
  - DONE: `cfg_ready=0`.
- Handshake occurs when `cfg_valid & cfg_ready`. `cfg_valid` without `cfg_ready` has no effect. Stalls (`cfg_valid=0`) hold state and index indefinitely.
- HDR handshake: mode register <= `cfg_data[0]`; go to LUT, idx=0. The mode bit is reflected into bit `LUT_W` of every `lut_mem` entry.
- LUT handshake: `table[idx]` <= `cfg_data[LUT_W-1:0]`; `lut_we[idx]` pulses. At idx=`NUM_LUT-1`, go to SB with idx=0; otherwise idx+1.
- SB handshake: `sb[idx]` <= `cfg_data[SB_W-1:0]`, upper bits ignored; `sb_we[idx]` pulses. At idx=`NUM_SB-1`, go to DONE; otherwise idx+1.
- `start` in any state: go to HDR, idx=0, `done=0`. If a handshake coincides with `start`, that word is consumed and discarded (no write, no `_we`).
- Restart does not clear stored config. Entries are retained until overwritten, but `fabric_en=0` until the new load completes.
- `busy=1` in HDR/LUT/SB.

## Timing
- Reset values: all `lut_mem`, `sb_cfg`, mode = 0; `lut_we`=`sb_we`=0; `cfg_ready`=`busy`=`done`=`fabric_en`=0; state IDLE.
- All outputs are registered.
- A data write and its `_we` pulse become visible in the cycle after the handshake.
- `start` sampled at edge N: `busy=1`, `cfg_ready=1`, `done=0` from cycle N+1.
- Minimum load time: 1+`NUM_LUT`+`NUM_SB` = 14 consecutive handshakes. `done`/`fabric_en` rise in the cycle after the 14th handshake, together with the last `sb_we` pulse, and `cfg_ready` falls at the same time.
- Throughput is one word per cycle; there is no bubble between the LUT and SB phases.
- Reset asserted mid-load takes effect at the next edge and wins over `start`.

## Structure
- Package `fabric_cfg_pkg`:
  - state enum (IDLE/HDR/LUT/SB/DONE);
  - constants `CFG_WORDS = 1+NUM_LUT+NUM_SB`;
  - `IDX_W = $clog2(NUM_LUT > NUM_SB ? NUM_LUT : NUM_SB)`.
- One sub-module, `cfg_word_demux`: given state, idx and a handshake, it produces the one-hot `lut_we`/`sb_we` strobes. Storage and the FSM live in the top.

## Test plan
- Reset, then stream 14 words back-to-back: word0=`32'h1`, LUT i=`32'hA5A5_0000+i`, SB j=`32'hFFFF_1230+j`. Required: `done` rises 1 cycle after the 14th handshake; entry 3 = `{1'b1, 32'hA5A5_0003}`; `sb_cfg` entry 4 = `16'h1234`; each `_we` pulses exactly once.
- Same stream with `cfg_valid` deasserted on every other cycle. Required: identical final contents; `done` rises 27 cycles after the first handshake.
- Assert `start` after 5 handshakes, coincident with a 6th valid word `32'hDEAD_BEEF`. Required: that word is not written, the loader returns to HDR, the next word is taken as the mode bit, and `done` remains 0 until 14 further handshakes.
- After `done`, hold `cfg_valid=1`. Required: `cfg_ready=0` and no `_we` pulses; contents unchanged.
- Assert `reset` at the 10th handshake. Required: next cycle all outputs 0, state IDLE, and `cfg_ready` stays 0 until `start`.
- Word0=`32'hFFFF_FFFE` followed by a full load. Required: mode bit 0 in all 8 entries (only bit 0 used).
